// File: rtl/trig_pkg.sv
// Shared constants, enums and the quadrant-fold helper for the angle front-end.
// Contents:
//   ANGLE_* constants : 90/180/270/360 degree reference points
//   DATA_WIDTH_DEF    : default width of the LUT reference-angle index
//   quadrant_t        : Q1..Q4 encoded 0..3
//   state_t           : reducer FSM states
//   fold_t            : quadrant plus 9-bit reference angle
//   quadrant_fold()   : maps a normalised angle 0..359 to (quadrant, reference angle)
package trig_pkg;

  localparam int unsigned ANGLE_90  = 90;
  localparam int unsigned ANGLE_180 = 180;
  localparam int unsigned ANGLE_270 = 270;
  localparam int unsigned ANGLE_360 = 360;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } quadrant_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REDUCE,
    ST_FOLD,
    ST_DONE
  } state_t;

  typedef struct packed {
    quadrant_t  q;
    logic [8:0] idx;
  } fold_t;

  // Boundary angles 90/180/270 belong to the lower quadrant, so the reference
  // index reaches 90 at 90 and 270, and 0 at 180.
  function automatic fold_t quadrant_fold(input logic [8:0] r);
    fold_t f;
    if (r <= 9'(ANGLE_90)) begin
      f.q   = Q1;
      f.idx = r;
    end else if (r <= 9'(ANGLE_180)) begin
      f.q   = Q2;
      f.idx = 9'(ANGLE_180) - r;
    end else if (r <= 9'(ANGLE_270)) begin
      f.q   = Q3;
      f.idx = r - 9'(ANGLE_180);
    end else begin
      f.q   = Q4;
      f.idx = 9'(ANGLE_360) - r;
    end
    return f;
  endfunction

endpackage

// File: rtl/angle_quadrant_reducer_if.sv
// Handshake bundle for angle_quadrant_reducer.
// Signals:
//   in_valid/in_ready/angle_in              : angle request (two's complement degrees)
//   out_valid/out_ready                     : result handshake (out_valid drives the LUT enable)
//   quadrant/angle_idx/angle_norm           : result fields
// Modports: master = producer/consumer side, slave = the reducer.
interface angle_quadrant_reducer_if #(
  parameter int ANGLE_W    = 16,
  parameter int DATA_WIDTH = trig_pkg::DATA_WIDTH_DEF
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ANGLE_W-1:0]    angle_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [1:0]            quadrant;
  logic [DATA_WIDTH-1:0] angle_idx;
  logic [8:0]            angle_norm;

  modport master (
    output in_valid, angle_in, out_ready,
    input  in_ready, out_valid, quadrant, angle_idx, angle_norm
  );

  modport slave (
    input  in_valid, angle_in, out_ready,
    output in_ready, out_valid, quadrant, angle_idx, angle_norm
  );
endinterface

// File: rtl/angle_mod360_unit.sv
// Iterative restoring mod-360 reducer: one conditional subtraction per step.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   load         : capture load_val into rem and restart at k = STEPS-1
//   load_val     : unsigned magnitude to reduce
//   step         : perform the step for the current k, then decrement k
//   last         : current k is 0 (the step taken now is the final one)
//   rem_out      : low 9 bits of the remainder (0..359 once reduction completes)
module angle_mod360_unit
  import trig_pkg::*;
#(
  parameter int ANGLE_W = 16,
  parameter int STEPS   = ANGLE_W - 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [ANGLE_W-1:0] load_val,
  input  logic               step,
  output logic               last,
  output logic [8:0]         rem_out
);

  localparam int KW = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic [ANGLE_W-1:0] rem_q;
  logic [KW-1:0]      k_q;
  logic [ANGLE_W:0]   sub_val;

  // One extra bit so 360<<k never wraps when compared against rem.
  assign sub_val = (ANGLE_W + 1)'(ANGLE_360) << k_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem_q <= '0;
      k_q   <= '0;
    end else if (load) begin
      rem_q <= load_val;
      k_q   <= KW'(STEPS - 1);
    end else if (step) begin
      if ({1'b0, rem_q} >= sub_val)
        rem_q <= rem_q - sub_val[ANGLE_W-1:0];
      if (k_q != '0)
        k_q <= k_q - KW'(1);
    end
  end

  assign last    = (k_q == '0);
  assign rem_out = rem_q[8:0];

endmodule

// File: rtl/angle_quadrant_reducer.sv
// Reduces a signed angle modulo 360 and folds it into quadrant + reference angle
// for the trig LUT stages.
// Ports:
//   clk     : clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : angle_quadrant_reducer_if.slave
//             (in_valid/in_ready/angle_in, out_valid/out_ready, quadrant, angle_idx, angle_norm)
// Latency: STEPS+1 cycles from accept to out_valid; one angle per STEPS+3 cycles.
module angle_quadrant_reducer
  import trig_pkg::*;
#(
  parameter int ANGLE_W    = 16,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int STEPS      = ANGLE_W - 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  angle_quadrant_reducer_if.slave     bus
);

  state_t             state_q, state_d;
  logic               load, step, last;
  logic               neg_q;
  logic [ANGLE_W-1:0] mag;
  logic [8:0]         rem9, r_fold;
  fold_t              fold;

  // |angle_in| as unsigned; the most negative value maps to 2^(ANGLE_W-1).
  assign mag = bus.angle_in[ANGLE_W-1] ? (~bus.angle_in + 1'b1) : bus.angle_in;

  angle_mod360_unit #(
    .ANGLE_W (ANGLE_W),
    .STEPS   (STEPS)
  ) u_mod (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (mag),
    .step     (step),
    .last     (last),
    .rem_out  (rem9)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        step = 1'b1;
        if (last)
          state_d = ST_FOLD;
      end
      ST_FOLD: state_d = ST_DONE;
      ST_DONE: begin
        if (bus.out_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      neg_q <= 1'b0;
    else if (load)
      neg_q <= bus.angle_in[ANGLE_W-1];
  end

  // Negative input: reflect the positive remainder; -0 and multiples of -360 stay 0.
  assign r_fold = (neg_q && rem9 != '0) ? (9'(ANGLE_360) - rem9) : rem9;
  assign fold   = quadrant_fold(r_fold);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.quadrant   <= '0;
      bus.angle_idx  <= '0;
      bus.angle_norm <= '0;
    end else if (state_q == ST_FOLD) begin
      bus.quadrant   <= fold.q;
      bus.angle_idx  <= DATA_WIDTH'(fold.idx);
      bus.angle_norm <= r_fold;
    end
  end

  // out_valid is exactly "in DONE": set by the FOLD->DONE edge, cleared by the
  // out_ready edge that returns to IDLE, and 0 after reset.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_angle_quadrant_reducer.sv
// Directed self-checking bench for angle_quadrant_reducer.
module tb_angle_quadrant_reducer;

  localparam int ANGLE_W = 16;
  localparam int DW      = 8;
  localparam int STEPS   = ANGLE_W - 8;

  logic clk = 1'b0;
  logic reset_n;
  int   vectors     = 0;
  int   miscompares = 0;

  angle_quadrant_reducer_if #(.ANGLE_W(ANGLE_W), .DATA_WIDTH(DW)) bus ();

  angle_quadrant_reducer #(
    .ANGLE_W    (ANGLE_W),
    .DATA_WIDTH (DW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Independent reference: plain arithmetic modulo and quadrant table.
  task automatic model(input int a, output int q, output int idx, output int norm);
    norm = a % 360;
    if (norm < 0) norm += 360;
    if (norm <= 90)       begin q = 0; idx = norm;       end
    else if (norm <= 180) begin q = 1; idx = 180 - norm; end
    else if (norm <= 270) begin q = 2; idx = norm - 180; end
    else                  begin q = 3; idx = 360 - norm; end
  endtask

  // Apply one angle from IDLE, check latency and result, optionally hold
  // out_ready low for 'hold' cycles (optionally driving a stray in_valid),
  // then release and check the single-cycle return to IDLE.
  task automatic run_angle(input string tag, input int a, input int eq, input int eidx,
                           input int enorm, input int hold, input bit stray);
    int cycles;
    @(negedge clk);
    bus.out_ready = (hold == 0);
    check({tag, " in_ready"}, 32'(bus.in_ready), 1);
    bus.angle_in = ANGLE_W'(a);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.out_valid && cycles < 40);
    check({tag, " latency"}, 32'(cycles), STEPS + 1);
    check({tag, " quadrant"}, 32'(bus.quadrant), 32'(eq));
    check({tag, " idx"}, 32'(bus.angle_idx), 32'(eidx));
    check({tag, " norm"}, 32'(bus.angle_norm), 32'(enorm));
    for (int i = 0; i < hold; i++) begin
      if (stray) begin
        bus.angle_in = ANGLE_W'(123);
        bus.in_valid = 1'b1;
      end
      @(negedge clk);
      check({tag, " hold out_valid"}, 32'(bus.out_valid), 1);
      check({tag, " hold in_ready"}, 32'(bus.in_ready), 0);
      check({tag, " hold quadrant"}, 32'(bus.quadrant), 32'(eq));
      check({tag, " hold idx"}, 32'(bus.angle_idx), 32'(eidx));
      check({tag, " hold norm"}, 32'(bus.angle_norm), 32'(enorm));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, " out_valid drop"}, 32'(bus.out_valid), 0);
    check({tag, " back to idle"}, 32'(bus.in_ready), 1);
  endtask

  initial begin
    int q, idx, norm;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.angle_in  = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset in_ready", 32'(bus.in_ready), 1);
    check("reset out_valid", 32'(bus.out_valid), 0);
    check("reset quadrant", 32'(bus.quadrant), 0);
    check("reset idx", 32'(bus.angle_idx), 0);
    check("reset norm", 32'(bus.angle_norm), 0);
    reset_n = 1'b1;

    run_angle("a45",    45,     0, 45, 45,  0, 1'b0);
    run_angle("a135",   135,    1, 45, 135, 0, 1'b0);
    run_angle("a210",   210,    2, 30, 210, 0, 1'b0);
    run_angle("a300",   300,    3, 60, 300, 0, 1'b0);
    run_angle("a90",    90,     0, 90, 90,  0, 1'b0);
    run_angle("a180",   180,    1, 0,  180, 0, 1'b0);
    run_angle("a270",   270,    2, 90, 270, 0, 1'b0);
    run_angle("a0",     0,      0, 0,  0,   0, 1'b0);
    run_angle("a720",   720,    0, 0,  0,   0, 1'b0);
    run_angle("a765",   765,    0, 45, 45,  0, 1'b0);
    run_angle("m30",    -30,    3, 30, 330, 0, 1'b0);
    run_angle("m360",   -360,   0, 0,  0,   0, 1'b0);
    run_angle("m32768", -32768, 3, 8,  352, 0, 1'b0);
    run_angle("p32767", 32767,  0, 7,  7,   0, 1'b0);

    // Backpressure with a stray request that must be dropped, not queued.
    run_angle("bp300", 300, 3, 60, 300, 5, 1'b1);
    repeat (14) @(negedge clk);
    check("stray not queued out_valid", 32'(bus.out_valid), 0);
    check("stray not queued in_ready", 32'(bus.in_ready), 1);

    // Reset landing on the fourth REDUCE edge aborts the angle in flight.
    @(negedge clk);
    bus.angle_in = ANGLE_W'(500);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid-reduce in_ready", 32'(bus.in_ready), 0);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort in_ready", 32'(bus.in_ready), 1);
    check("abort out_valid", 32'(bus.out_valid), 0);
    check("abort norm", 32'(bus.angle_norm), 0);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort no output", 32'(bus.out_valid), 0);
    run_angle("a60 after reset", 60, 0, 60, 60, 0, 1'b0);

    // Sweep against the arithmetic model with random hold-off on out_ready.
    for (int a = -720; a <= 720; a += 45) begin
      model(a, q, idx, norm);
      run_angle("sweep", a, q, idx, norm, int'($urandom_range(0, 2)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
